// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: Moore FSM whose next-state table is derived from
// PATTERN at elaboration (KMP failure rule), with overlap select, clock enable and match counter.
module seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             en,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int SW = $clog2(PAT_LEN + 1);
  localparam int NS = 1 << SW;

  localparam logic [SW-1:0] S0    = '0;
  localparam logic [SW-1:0] MATCH = SW'(PAT_LEN);

  if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_len
    $fatal(1, "seq_detector_param: PAT_LEN=%0d outside 2..32", PAT_LEN);
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
    $fatal(1, "seq_detector_param: CNT_W=%0d outside 1..32", CNT_W);
  end

  // Next state from Sk on bit b: the history is the k-bit pattern prefix followed by b,
  // newest bit in position 0. Pick the longest suffix of that history that is also a
  // pattern prefix. For k=PAT_LEN this is the overlapping re-entry out of MATCH.
  function automatic logic [SW-1:0] kmp_next(input int k, input logic b);
    logic [32:0] h;
    logic [32:0] pre;
    logic [32:0] msk;
    int          lim;
    int          best;
    h    = ({1'b0, 32'(PATTERN)} >> (PAT_LEN - k)) << 1;
    h[0] = b;
    lim  = (k + 1 < PAT_LEN) ? k + 1 : PAT_LEN;
    best = 0;
    for (int j = 1; j <= lim; j++) begin
      msk = (33'd1 << j) - 33'd1;
      pre = ({1'b0, 32'(PATTERN)} >> (PAT_LEN - j)) & msk;
      if ((h & msk) == pre) best = j;
    end
    return SW'(best);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [SW-1:0] tab0 [NS];
  logic [SW-1:0] tab1 [NS];

  // Unreachable encodings above MATCH fall back to S0.
  for (genvar k = 0; k < NS; k++) begin : g_tab
    if (k <= PAT_LEN) begin : g_live
      localparam logic [SW-1:0] N0 = kmp_next(k, 1'b0);
      localparam logic [SW-1:0] N1 = kmp_next(k, 1'b1);
      assign tab0[k] = N0;
      assign tab1[k] = N1;
    end else begin : g_dead
      assign tab0[k] = S0;
      assign tab1[k] = S0;
    end
  end

  logic [SW-1:0]    state;
  logic [SW-1:0]    nxt_state;
  logic             hit;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    nxt_state = state;
    if (en) begin
      if (state == MATCH && !overlap) nxt_state = x ? tab1[S0] : tab0[S0];
      else                            nxt_state = x ? tab1[state] : tab0[state];
    end
  end

  assign hit     = en & (nxt_state == MATCH);
  assign cnt_nxt = hit ? sat_inc(match_cnt) : match_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      state <= nxt_state;
      if (clr_cnt) begin
        match_cnt <= '0;
        cnt_sat   <= 1'b0;
      end else begin
        match_cnt <= cnt_nxt;
        cnt_sat   <= cnt_sat | (&cnt_nxt);
      end
    end
  end

  assign y = (state == MATCH);

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three configurations share one stimulus stream and are
// scored against a sliding-window reference model through a scoreboard queue.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       x = 1'b0;
  logic       en = 1'b0;
  logic       overlap = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       y0, y1, y2, s0, s1, s2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  seq_detector_param u_def (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .overlap(overlap), .clr_cnt(clr_cnt),
    .y(y0), .match_cnt(c0), .cnt_sat(s0));

  seq_detector_param #(.PAT_LEN(3), .PATTERN(3'b111), .CNT_W(8)) u_111 (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .overlap(overlap), .clr_cnt(clr_cnt),
    .y(y1), .match_cnt(c1), .cnt_sat(s1));

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1001), .CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .overlap(overlap), .clr_cnt(clr_cnt),
    .y(y2), .match_cnt(c2), .cnt_sat(s2));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          inst;
    logic        y;
    logic [31:0] cnt;
    logic        sat;
  } exp_t;
  exp_t sb[$];

  int          plen[3] = '{4, 3, 4};
  logic [31:0] pat[3]  = '{32'h9, 32'h7, 32'h9};
  int          cmax[3] = '{255, 255, 3};
  logic [31:0] hist[3];
  int          hlen[3];
  logic        mprev[3];
  int          mcnt[3];
  logic        msat[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      hist[i] = '0; hlen[i] = 0; mprev[i] = 1'b0; mcnt[i] = 0; msat[i] = 1'b0;
    end
  endfunction

  // Reference: keep the bits received since the last restart and compare the newest
  // plen bits against the pattern; a non-overlapping match restarts the history.
  function automatic void model_edge(input int i, input logic xb, input logic e,
                                     input logic ov, input logic cl);
    logic        m;
    logic [31:0] mask;
    m    = 1'b0;
    mask = (plen[i] == 32) ? '1 : ((32'd1 << plen[i]) - 32'd1);
    if (e) begin
      if (mprev[i] && !ov) hlen[i] = 0;
      hist[i] = {hist[i][30:0], xb};
      if (hlen[i] < 32) hlen[i]++;
      m = (hlen[i] >= plen[i]) && ((hist[i] & mask) == pat[i]);
      mprev[i] = m;
    end
    if (cl) begin
      mcnt[i] = 0;
      msat[i] = 1'b0;
    end else if (m && mcnt[i] < cmax[i]) begin
      mcnt[i]++;
      if (mcnt[i] == cmax[i]) msat[i] = 1'b1;
    end
  endfunction

  task automatic get_dut(input int i, output logic gy, output logic [31:0] gc, output logic gs);
    case (i)
      0:       begin gy = y0; gc = 32'(c0); gs = s0; end
      1:       begin gy = y1; gc = 32'(c1); gs = s1; end
      default: begin gy = y2; gc = 32'(c2); gs = s2; end
    endcase
  endtask

  task automatic step(input string tag, input logic xb, input logic e,
                      input logic ov, input logic cl);
    exp_t        ex;
    logic        gy, gs;
    logic [31:0] gc;
    x = xb; en = e; overlap = ov; clr_cnt = cl;
    for (int i = 0; i < 3; i++) begin
      model_edge(i, xb, e, ov, cl);
      ex.inst = i; ex.y = mprev[i]; ex.cnt = 32'(mcnt[i]); ex.sat = msat[i];
      sb.push_back(ex);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        ex = sb.pop_front();
        get_dut(ex.inst, gy, gc, gs);
        check($sformatf("%s_y%0d", tag, ex.inst), 32'(gy), 32'(ex.y));
        check($sformatf("%s_cnt%0d", tag, ex.inst), gc, ex.cnt);
        check($sformatf("%s_sat%0d", tag, ex.inst), 32'(gs), 32'(ex.sat));
      end
    end
  endtask

  task automatic drive_bits(input string tag, input logic [31:0] bits, input int n,
                            input logic ov);
    logic [31:0] t;
    for (int k = 0; k < n; k++) begin
      t = bits >> (n - 1 - k);
      step(tag, t[0], 1'b1, ov, 1'b0);
    end
  endtask

  task automatic check_reset(input string tag);
    logic        gy, gs;
    logic [31:0] gc;
    for (int i = 0; i < 3; i++) begin
      get_dut(i, gy, gc, gs);
      check($sformatf("%s_y%0d", tag, i), 32'(gy), 32'(mprev[i]));
      check($sformatf("%s_cnt%0d", tag, i), gc, 32'(mcnt[i]));
      check($sformatf("%s_sat%0d", tag, i), 32'(gs), 32'(msat[i]));
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    sb.delete();
    #1;
    check_reset(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2;
    do_reset("rst0");

    // T1 / T2: default pattern on the reference stream, both modes
    drive_bits("t1", 32'b0010011001001001110, 19, 1'b1);
    check("t1_final_cnt", 32'(c0), 32'd4);
    do_reset("rst1");
    drive_bits("t2", 32'b0010011001001001110, 19, 1'b0);
    check("t2_final_cnt", 32'(c0), 32'd3);

    // T3: run of ones, both modes
    do_reset("rst2");
    drive_bits("t3o", 32'b11111, 5, 1'b1);
    check("t3o_cnt111", 32'(c1), 32'd3);
    do_reset("rst3");
    drive_bits("t3n", 32'b11111, 5, 1'b0);
    check("t3n_cnt111", 32'(c1), 32'd1);

    // T4: stall with x toggling between the third and fourth pattern bits
    do_reset("rst4");
    step("t4", 1'b1, 1'b1, 1'b1, 1'b0);
    step("t4", 1'b0, 1'b1, 1'b1, 1'b0);
    step("t4", 1'b0, 1'b1, 1'b1, 1'b0);
    step("t4s", 1'b0, 1'b0, 1'b1, 1'b0);
    step("t4s", 1'b1, 1'b0, 1'b1, 1'b0);
    step("t4s", 1'b0, 1'b0, 1'b1, 1'b0);
    step("t4", 1'b1, 1'b1, 1'b1, 1'b0);
    check("t4_match", 32'(y0), 32'd1);

    // T5: saturate the 2-bit counter, then clear on a matching edge and while stalled
    do_reset("rst5");
    drive_bits("t5", 32'b1001001001001001, 16, 1'b1);
    check("t5_c2_sat_cnt", 32'(c2), 32'd3);
    check("t5_c2_sat_flag", 32'(s2), 32'd1);
    step("t5c", 1'b0, 1'b1, 1'b1, 1'b0);
    step("t5c", 1'b0, 1'b1, 1'b1, 1'b0);
    step("t5c", 1'b1, 1'b1, 1'b1, 1'b1);
    check("t5_clr_cnt", 32'(c2), 32'd0);
    drive_bits("t5d", 32'b001, 3, 1'b1);
    step("t5e", 1'b0, 1'b0, 1'b1, 1'b1);
    step("t5h", 1'b1, 1'b0, 1'b0, 1'b0);

    // T6: asynchronous reset after three matched bits
    drive_bits("t6", 32'b1001100, 7, 1'b0);
    #3;
    rst_n = 1'b0;
    model_reset();
    sb.delete();
    #1;
    check_reset("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    step("t6_after", 1'b1, 1'b1, 1'b1, 1'b0);
    check("t6_no_match", 32'(y0), 32'd0);

    // Mixed random traffic
    for (int n = 0; n < 300; n++) begin
      step("rnd", 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
